lsu_mem_master: RTL

- Load/store initiator between the RV32 core datapath and the word-wide data memory. The memory has combinational read, a synchronous write, and no byte enables.
- Accepts one load or store per handshake and drives mem_a/mem_we/mem_wd. Extracts and sign/zero-extends sub-word loads.
- Implements sb/sh as read-modify-write. Rejects misaligned or illegal accesses with an error response.
- Multi-cycle: core stalls on req_ready.

---
 rtl/riscv_mem_pkg.sv | 40 ++++
 rtl/lsu_byte_lane.sv | 44 ++++
 rtl/lsu_mem_master.sv | 124 ++++++++++++
 3 files changed

// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the load/store path: funct3 encodings, LSU states,
// access sizes, and small decode helpers used by the LSU and the byte lane.
package riscv_mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_RMW_RD = 3'd2,
    ST_WRITE  = 3'd3,
    ST_RESP   = 3'd4
  } lsu_state_t;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } access_size_t;

  // Size only depends on funct3[1:0]; the unsigned flag lives in funct3[2].
  function automatic access_size_t f3_size(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return SZ_B;
      2'b01:   return SZ_H;
      default: return SZ_W;
    endcase
  endfunction

  function automatic logic f3_legal(input logic we, input logic [2:0] f3);
    if (we) return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
           (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

endpackage

// File: rtl/lsu_byte_lane.sv
// Combinational byte-lane steering: sub-word load extract/extend and
// sb/sh merge of store data into an existing memory word.
module lsu_byte_lane
  import riscv_mem_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] store_data
);

  logic [7:0]   byte_v;
  logic [15:0]  half_v;
  logic [4:0]   bit_base;
  access_size_t sz;

  always_comb begin
    bit_base   = {addr_lo, 3'b000};
    sz         = f3_size(funct3);
    byte_v     = word[bit_base +: 8];
    half_v     = addr_lo[1] ? word[31:16] : word[15:0];
    load_data  = word;
    store_data = word;
    // funct3[2] set means unsigned, so the sign bit is masked off.
    case (sz)
      SZ_B: begin
        load_data = {{24{byte_v[7] & ~funct3[2]}}, byte_v};
        store_data[bit_base +: 8] = wdata[7:0];
      end
      SZ_H: begin
        load_data = {{16{half_v[15] & ~funct3[2]}}, half_v};
        if (addr_lo[1]) store_data[31:16] = wdata[15:0];
        else            store_data[15:0]  = wdata[15:0];
      end
      default: begin
        load_data  = word;
        store_data = wdata;
      end
    endcase
  end

endmodule

// File: rtl/lsu_mem_master.sv
// Multi-cycle load/store initiator for a word-wide memory without byte
// enables; sub-word stores are done as read-modify-write.
module lsu_mem_master
  import riscv_mem_pkg::*;
#(
  parameter int ADDR_W        = 32,
  parameter bit ERR_ZERO_DATA = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_a,
  output logic [31:0]       mem_wd,
  input  logic [31:0]       mem_rd
);

  lsu_state_t        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [2:0]        funct3_q, funct3_d;
  logic              we_q, we_d;
  logic [31:0]       merge_q, merge_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;

  access_size_t req_sz;
  logic         req_bad;
  logic [31:0]  lane_load, lane_store;

  lsu_byte_lane u_lane (
    .addr_lo    (addr_q[1:0]),
    .funct3     (funct3_q),
    .word       (mem_rd),
    .wdata      (wdata_q),
    .load_data  (lane_load),
    .store_data (lane_store)
  );

  always_comb begin
    req_sz  = f3_size(req_funct3);
    req_bad = !f3_legal(req_we, req_funct3) ||
              (req_sz == SZ_H && req_addr[0]) ||
              (req_sz == SZ_W && req_addr[1:0] != 2'b00);
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    funct3_d = funct3_q;
    we_d     = we_q;
    merge_d  = merge_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          funct3_d = req_funct3;
          we_d     = req_we;
          err_d    = req_bad;
          if (ERR_ZERO_DATA) rdata_d = '0;
          if (req_bad)            state_d = ST_RESP;
          else if (!req_we)       state_d = ST_LOAD;
          else if (req_sz == SZ_W) state_d = ST_WRITE;
          else                    state_d = ST_RMW_RD;
        end
      end
      ST_LOAD: begin
        rdata_d = lane_load;
        state_d = ST_RESP;
      end
      ST_RMW_RD: begin
        merge_d = lane_store;
        state_d = ST_WRITE;
      end
      ST_WRITE: state_d = ST_RESP;
      ST_RESP:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      funct3_q <= '0;
      we_q     <= 1'b0;
      merge_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      funct3_q <= funct3_d;
      we_q     <= we_d;
      merge_q  <= merge_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  // Write enable is decoded from the state register so reset kills it at once.
  assign req_ready  = (state_q == ST_IDLE);
  assign resp_valid = (state_q == ST_RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  assign mem_we     = (state_q == ST_WRITE) && we_q;
  assign mem_a      = {addr_q[ADDR_W-1:2], 2'b00};
  assign mem_wd     = (f3_size(funct3_q) == SZ_W) ? wdata_q : merge_q;

endmodule
